// File: rtl/xf100_exu_wbck_arb_pkg.sv
// Shared definitions for the xf100 writeback arbiter.
// Holds default widths, the starvation threshold default, the starvation counter
// width and the write-source encoding.
package xf100_exu_wbck_arb_pkg;

  localparam int unsigned XF100_XLEN      = 32;
  localparam int unsigned XF100_RFIDX_W   = 5;
  localparam int unsigned WBCK_STARVE_MAX = 4;
  localparam int unsigned WBCK_CNT_W      = 4;

  // Source tag carried alongside each regfile write.
  typedef enum logic {
    WBCK_SRC_ALU = 1'b0,
    WBCK_SRC_LSU = 1'b1
  } wbck_src_e;

endpackage

// File: rtl/xf100_exu_wbck_prio.sv
// Grant logic for the writeback arbiter.
// Inputs are "real" requests, meaning valid with a non-x0 destination. At most one
// grant is asserted. The ALU has priority unless the optional starvation counter has
// reached STARVE_MAX.
// Optional feature macro: XF100_WBCK_STARVE_EN (adds clk/rst_n ports and the counter).
// Ports:
//   clk, rst_n            counter clock/reset (XF100_WBCK_STARVE_EN only)
//   alu_req_i, lsu_req_i  real write requests
//   alu_gnt_o, lsu_gnt_o  combinational grants
module xf100_exu_wbck_prio
  import xf100_exu_wbck_arb_pkg::*;
`ifdef XF100_WBCK_STARVE_EN
#(
  parameter int unsigned STARVE_MAX = WBCK_STARVE_MAX
)
`endif
(
`ifdef XF100_WBCK_STARVE_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic alu_req_i,
  input  logic lsu_req_i,
  output logic alu_gnt_o,
  output logic lsu_gnt_o
);

  logic lsu_first;

`ifdef XF100_WBCK_STARVE_EN
  localparam logic [WBCK_CNT_W-1:0] CNT_MAX = WBCK_CNT_W'(STARVE_MAX);

  logic [WBCK_CNT_W-1:0] cnt_q, cnt_d;

  // Count lost LSU cycles and saturate. Clear on an LSU grant. Hold while the LSU is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (lsu_gnt_o) begin
      cnt_d = '0;
    end else if (lsu_req_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + WBCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lsu_first = (cnt_q == CNT_MAX);
`else
  assign lsu_first = 1'b0;
`endif

  // Fixed priority with the order flipped by lsu_first. The two grants are mutually exclusive.
  assign alu_gnt_o = alu_req_i & ~(lsu_req_i & lsu_first);
  assign lsu_gnt_o = lsu_req_i & ~(alu_req_i & ~lsu_first);

endmodule

// File: rtl/xf100_exu_wbck_arb.sv
// Writeback arbiter that shares the single regfile write port between the ALU and the LSU.
// A transfer happens when valid & ready in cycle N. The write appears on arb_o_* in cycle N+1.
// A result with destination x0 is acknowledged at once and dropped. It never blocks the other source.
// Optional feature macro: XF100_WBCK_STARVE_EN (the LSU gets priority after STARVE_MAX lost cycles).
// Ports:
//   clk, rst_n                        core clock, async active-low reset
//   alu_i_wbck_valid/data/rdidx       ALU result, alu_o_wbck_ready acknowledges it
//   lsu_i_wbck_valid/data/rdidx       LSU result, lsu_o_wbck_ready acknowledges it
//   arb_o_wbck_en/data/rdidx/src      registered regfile write port (src: 0=ALU, 1=LSU)
module xf100_exu_wbck_arb
  import xf100_exu_wbck_arb_pkg::*;
#(
  parameter int unsigned XLEN       = XF100_XLEN,
  parameter int unsigned RFIDX_W    = XF100_RFIDX_W
`ifdef XF100_WBCK_STARVE_EN
  ,
  parameter int unsigned STARVE_MAX = WBCK_STARVE_MAX
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_i_wbck_valid,
  output logic               alu_o_wbck_ready,
  input  logic [XLEN-1:0]    alu_i_wbck_data,
  input  logic [RFIDX_W-1:0] alu_i_wbck_rdidx,
  input  logic               lsu_i_wbck_valid,
  output logic               lsu_o_wbck_ready,
  input  logic [XLEN-1:0]    lsu_i_wbck_data,
  input  logic [RFIDX_W-1:0] lsu_i_wbck_rdidx,
  output logic               arb_o_wbck_en,
  output logic [XLEN-1:0]    arb_o_wbck_data,
  output logic [RFIDX_W-1:0] arb_o_wbck_rdidx,
  output logic               arb_o_wbck_src
);

  typedef struct packed {
    wbck_src_e          src;
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    data;
  } wbck_t;

  logic  alu_req, lsu_req;
  logic  alu_gnt, lsu_gnt;
  logic  en_q, en_d;
  wbck_t wb_q, wb_d;

  // Only writes to a non-x0 destination compete for the port.
  assign alu_req = alu_i_wbck_valid & (|alu_i_wbck_rdidx);
  assign lsu_req = lsu_i_wbck_valid & (|lsu_i_wbck_rdidx);

  xf100_exu_wbck_prio
`ifdef XF100_WBCK_STARVE_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
  u_prio (
`ifdef XF100_WBCK_STARVE_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .alu_req_i (alu_req),
    .lsu_req_i (lsu_req),
    .alu_gnt_o (alu_gnt),
    .lsu_gnt_o (lsu_gnt)
  );

  // An x0 write (valid without req) is acknowledged at once. Hold both readies low while in reset.
  assign alu_o_wbck_ready = rst_n & alu_i_wbck_valid & (~alu_req | alu_gnt);
  assign lsu_o_wbck_ready = rst_n & lsu_i_wbck_valid & (~lsu_req | lsu_gnt);

  // Capture the winner's payload. The data/rdidx/src fields keep their old values when nothing wins.
  always_comb begin
    en_d = alu_gnt | lsu_gnt;
    wb_d = wb_q;
    if (lsu_gnt) begin
      wb_d = '{src: WBCK_SRC_LSU, rdidx: lsu_i_wbck_rdidx, data: lsu_i_wbck_data};
    end else if (alu_gnt) begin
      wb_d = '{src: WBCK_SRC_ALU, rdidx: alu_i_wbck_rdidx, data: alu_i_wbck_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      wb_q <= '0;
    end else begin
      en_q <= en_d;
      wb_q <= wb_d;
    end
  end

  assign arb_o_wbck_en    = en_q;
  assign arb_o_wbck_data  = wb_q.data;
  assign arb_o_wbck_rdidx = wb_q.rdidx;
  assign arb_o_wbck_src   = wb_q.src;

endmodule
